// File: rtl/slicel_config_loader.sv
// Serial LSB-first config loader for one slicel: 143 data bits plus an even-parity trailer, committed atomically.
// 145 cycles from accepted start at full rate; bit_valid low stalls one cycle each, with no timeout.
module slicel_config_loader #(
  parameter int S_XX_BASE = 4,
  parameter int NUM_LUTS  = 4,
  parameter int MUX_LVLS  = $clog2(NUM_LUTS),
  parameter int CFG_SIZE  = 2*(2**S_XX_BASE)+1,
  localparam int CFG_BITS = CFG_SIZE*NUM_LUTS+MUX_LVLS+1+2*NUM_LUTS
) (
  input  logic                         cclk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  output logic                         bit_ready,
  output logic [CFG_SIZE*NUM_LUTS-1:0] luts_config_in,
  output logic [MUX_LVLS-1:0]          inter_lut_mux_config,
  output logic                         config_use_cc,
  output logic [2*NUM_LUTS-1:0]        regs_config_in,
  output logic                         cen,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int CNT_W = $clog2(CFG_BITS+1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS-1);

  // Field order mirrors the frame: first bit received is luts[0].
  typedef struct packed {
    logic [2*NUM_LUTS-1:0]        regs;
    logic                         use_cc;
    logic [MUX_LVLS-1:0]          mux;
    logic [CFG_SIZE*NUM_LUTS-1:0] luts;
  } cfg_t;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, COMMIT} state_t;

  state_t              state, state_nxt;
  logic [CFG_BITS-1:0] shadow;
  logic [CNT_W-1:0]    bit_cnt;
  cfg_t                cfg_q;
  logic                accept;
  logic                parity_ok;

  assign accept    = bit_ready & bit_valid;
  assign parity_ok = ~((^shadow) ^ bit_in);

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (accept && bit_cnt == CNT_LAST) state_nxt = CHECK;
      CHECK:   if (accept) state_nxt = parity_ok ? COMMIT : IDLE;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      bit_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cen       <= 1'b1;
      shadow    <= '0;
      bit_cnt   <= '0;
      cfg_q     <= '0;
    end else begin
      // Status flags are decoded from the next state so they line up with it.
      bit_ready <= (state_nxt == SHIFT) || (state_nxt == CHECK);
      busy      <= (state_nxt != IDLE);
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err     <= 1'b0;
            bit_cnt <= '0;
            cen     <= 1'b1;
          end
        end
        SHIFT: begin
          if (accept) begin
            shadow  <= {bit_in, shadow[CFG_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (accept && !parity_ok) err <= 1'b1;
        end
        COMMIT: begin
          cfg_q <= cfg_t'(shadow);
          done  <= 1'b1;
          cen   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign luts_config_in       = cfg_q.luts;
  assign inter_lut_mux_config = cfg_q.mux;
  assign config_use_cc        = cfg_q.use_cc;
  assign regs_config_in       = cfg_q.regs;

endmodule

// File: tb/tb_slicel_config_loader.sv
// Directed and randomized frames for slicel_config_loader, checked against a frame-level model of the config outputs.
module tb_slicel_config_loader;

  localparam int CB = 143;
  localparam int NL = 132;

  logic          cclk, rst, start, bit_in, bit_valid;
  logic          bit_ready, config_use_cc, cen, busy, done, err;
  logic [NL-1:0] luts_config_in;
  logic [1:0]    inter_lut_mux_config;
  logic [7:0]    regs_config_in;

  int            checks, errors;
  logic [CB-1:0] exp_cfg;
  logic [CB-1:0] frm;

  slicel_config_loader dut (
    .cclk                 (cclk),
    .rst                  (rst),
    .start                (start),
    .bit_in               (bit_in),
    .bit_valid            (bit_valid),
    .bit_ready            (bit_ready),
    .luts_config_in       (luts_config_in),
    .inter_lut_mux_config (inter_lut_mux_config),
    .config_use_cc        (config_use_cc),
    .regs_config_in       (regs_config_in),
    .cen                  (cen),
    .busy                 (busy),
    .done                 (done),
    .err                  (err)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [CB-1:0] obs, input logic [CB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame bit i maps to output field by position: luts [131:0], mux [133:132], use_cc [134], regs [142:135].
  task automatic chk_cfg(input string tag);
    chkw({tag, "_luts"}, CB'(luts_config_in), CB'(exp_cfg[NL-1:0]));
    chkw({tag, "_mux"}, CB'(inter_lut_mux_config), CB'(exp_cfg[NL+1:NL]));
    chk1({tag, "_cc"}, config_use_cc, exp_cfg[NL+2]);
    chkw({tag, "_regs"}, CB'(regs_config_in), CB'(exp_cfg[CB-1:NL+3]));
  endtask

  task automatic rand_frame(output logic [CB-1:0] d);
    for (int i = 0; i < CB; i++) d[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic load_frame(input string tag, input logic [CB-1:0] data, input logic par,
                            input int stall_every, input int poke_at);
    int   edge_n, stalls, k, got;
    logic good;
    good = ((^data) ^ par) == 1'b0;
    start = 1'b1;
    @(posedge cclk); #1;
    start = 1'b0;
    chk1({tag, "_busy_start"}, busy, 1'b1);
    chk1({tag, "_rdy_start"}, bit_ready, 1'b1);
    chk1({tag, "_cen_start"}, cen, 1'b1);
    chk1({tag, "_err_clr"}, err, 1'b0);
    edge_n = 0;
    stalls = 0;
    k      = 0;
    while (k <= CB) begin
      start = 1'b0;
      if (stall_every > 1 && (edge_n + 1) % stall_every == 0) begin
        bit_valid = 1'b0;
        stalls++;
      end else begin
        bit_valid = 1'b1;
        if (k == poke_at) start = 1'b1;
        if (k < CB) bit_in = data[k];
        else        bit_in = par;
        k++;
      end
      @(posedge cclk); #1;
      edge_n++;
    end
    bit_valid = 1'b0;
    start     = 1'b0;
    bit_in    = 1'b0;
    if (good) begin
      chk1({tag, "_busy_commit"}, busy, 1'b1);
      chk1({tag, "_rdy_commit"}, bit_ready, 1'b0);
      chk1({tag, "_done_early"}, done, 1'b0);
      chk1({tag, "_cen_commit"}, cen, 1'b1);
      chk_cfg({tag, "_hold"});
      got = -1;
      for (int i = 0; i < 4 && got < 0; i++) begin
        @(posedge cclk); #1;
        edge_n++;
        if (done === 1'b1) got = edge_n;
      end
      chk_int({tag, "_done_edge"}, got, CB + 2 + stalls);
      exp_cfg = data;
      chk1({tag, "_cen_done"}, cen, 1'b0);
      chk1({tag, "_busy_done"}, busy, 1'b0);
      chk1({tag, "_err_done"}, err, 1'b0);
      chk_cfg({tag, "_out"});
      @(posedge cclk); #1;
      chk1({tag, "_done_fall"}, done, 1'b0);
      chk1({tag, "_rdy_idle"}, bit_ready, 1'b0);
    end else begin
      chk1({tag, "_err_rise"}, err, 1'b1);
      chk1({tag, "_busy_fall"}, busy, 1'b0);
      chk1({tag, "_rdy_fall"}, bit_ready, 1'b0);
      chk1({tag, "_cen_held"}, cen, 1'b1);
      chk_cfg({tag, "_kept"});
      got = 0;
      for (int i = 0; i < 3; i++) begin
        @(posedge cclk); #1;
        if (done !== 1'b0) got++;
      end
      chk_int({tag, "_no_done"}, got, 0);
      chk1({tag, "_err_sticky"}, err, 1'b1);
      chk1({tag, "_cen_sticky"}, cen, 1'b1);
    end
  endtask

  initial begin
    int sv;
    logic par;
    checks    = 0;
    errors    = 0;
    exp_cfg   = '0;
    rst       = 1'b1;
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    repeat (2) @(posedge cclk);
    #1;
    chk_cfg("reset");
    chk1("reset_cen", cen, 1'b1);
    chk1("reset_rdy", bit_ready, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_err", err, 1'b0);
    rst = 1'b0;
    @(posedge cclk); #1;

    frm = '1;
    load_frame("ones", frm, 1'b1, 0, -1);
    chkw("ones_regs_lit", CB'(regs_config_in), CB'(8'hFF));

    frm      = '0;
    frm[0]   = 1'b1;
    frm[133] = 1'b1;
    frm[142] = 1'b1;
    load_frame("fmap", frm, 1'b1, 0, -1);
    chkw("fmap_luts_lit", CB'(luts_config_in), CB'(1));
    chkw("fmap_mux_lit", CB'(inter_lut_mux_config), CB'(2'b10));
    chk1("fmap_cc_lit", config_use_cc, 1'b0);
    chkw("fmap_regs_lit", CB'(regs_config_in), CB'(8'h80));

    frm = '1;
    load_frame("perr", frm, 1'b0, 0, -1);

    rand_frame(frm);
    load_frame("after_err", frm, ^frm, 0, -1);

    frm = '1;
    load_frame("stall", frm, 1'b1, 3, -1);

    rand_frame(frm);
    load_frame("poke", frm, ^frm, 0, 50);

    start = 1'b1;
    @(posedge cclk); #1;
    start     = 1'b0;
    bit_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      bit_in = 1'($urandom_range(0, 1));
      @(posedge cclk); #1;
    end
    bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    exp_cfg = '0;
    chk_cfg("rst_mid");
    chk1("rst_mid_cen", cen, 1'b1);
    chk1("rst_mid_busy", busy, 1'b0);
    chk1("rst_mid_rdy", bit_ready, 1'b0);
    chk1("rst_mid_err", err, 1'b0);
    @(posedge cclk); #1;
    rst = 1'b0;
    @(posedge cclk); #1;

    rand_frame(frm);
    load_frame("after_rst", frm, ^frm, 0, -1);

    for (int n = 0; n < 4; n++) begin
      rand_frame(frm);
      par = (^frm) ^ ($urandom_range(0, 3) == 0);
      sv  = $urandom_range(1, 5);
      if (sv == 1) sv = 0;
      load_frame($sformatf("rnd%0d", n), frm, par, sv, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slicel_config_loader.md
# slicel_config_loader

Serial configuration loader for one `slicel`. It receives a framed, LSB-first bitstream over a valid/ready bit interface and checks an even-parity trailer bit. On a good frame it atomically commits the 143-bit parallel configuration (LUT memories, inter-LUT mux selects, carry-chain enable, register init values) and releases `cen` so the slice leaves config mode. It sits between the fabric configuration chain and each slicel's parallel config ports, and is the producer side of the bitstream that the slicel testbench loads directly.

## Interface
- `S_XX_BASE`, 4, LUT input base width.
- `NUM_LUTS`, 4, LUTs per slice.
- `MUX_LVLS`, `$clog2(NUM_LUTS)` = 2, inter-LUT mux levels.
- `CFG_SIZE`, `2*(2**S_XX_BASE)+1` = 33, config bits per LUT.
- `CFG_BITS`, `CFG_SIZE*NUM_LUTS+MUX_LVLS+1+2*NUM_LUTS` = 143, data bits per frame (derived, not overridden).

Ports:
- `cclk` in 1: config clock; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request a new frame; honoured only in IDLE.
- `bit_in` in 1: serial config bit.
- `bit_valid` in 1: `bit_in` is valid.
- `bit_ready` out 1: loader accepts a bit this cycle.
- `luts_config_in` out `CFG_SIZE*NUM_LUTS` (132): frame bits [131:0].
- `inter_lut_mux_config` out `MUX_LVLS` (2): frame bits [133:132]; bit 1 is f8mux, bit 0 is f7mux.
- `config_use_cc` out 1: frame bit [134].
- `regs_config_in` out `2*NUM_LUTS` (8): frame bits [142:135].
- `cen` out 1: slice config enable; high means config mode.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on successful commit.
- `err` out 1: parity failure; sticky until the next accepted `start` or `rst`.

## Operation
- States:
  - IDLE: `bit_ready`=0. `start`=1 goes to SHIFT, clears `err` and the bit counter, and sets `cen`=1.
  - SHIFT: `bit_ready`=1. Each cycle with `bit_valid`, the loader shifts `bit_in` into the MSB of a 143-bit shadow register, shifting right, and increments the counter. The first received bit therefore lands at index 0. On the 143rd accepted bit it goes to CHECK.
  - CHECK: `bit_ready`=1. The accepted bit is the parity bit P.
    - If XOR(shadow) ^ P = 0, go to COMMIT.
    - Otherwise go to IDLE with `err`=1. Output registers and `cen` are unchanged.
  - COMMIT: `bit_ready`=0. Copy the shadow register into the output registers, pulse `done`, clear `cen`, then go to IDLE.
- `bit_valid` low in SHIFT or CHECK stalls the loader; there is no timeout. `bit_in` is ignored whenever `bit_ready`=0.
- `start` in any state other than IDLE is ignored and does not restart the frame.
- Output config registers change only in COMMIT, so the slice never sees a partial frame.
- `cen` stays 1 from an accepted `start` until a successful COMMIT. After a parity error it stays 1 and the old config is held.
- Counter width is `$clog2(CFG_BITS+1)` = 8 bits. It never exceeds 143 and has no wrap-around.

## Timing
- Reset values:
  - All config outputs 0.
  - `cen`=1.
  - `bit_ready`, `busy`, `done`, `err` = 0.
  - State IDLE; shadow register and counter 0.
- Assertion of `rst` mid-frame aborts immediately, discards the shadow, and zeroes the config outputs.
- `bit_ready` and `busy` are registered state decodes and are valid the cycle after the transition edge.
- Latency, taking the edge that samples `start` as edge 0, with `bit_valid` held high:
  - data bits sampled at edges 1..143;
  - parity sampled at edge 144;
  - COMMIT occupies the following cycle.
  - At edge 145 the outputs update, `done`=1 and `cen`=0; `done` returns to 0 at edge 146.
  - Total is 145 cycles; each stalled cycle adds one.
- On a parity error, `err` rises at the edge that samples P (edge 144), and `busy` falls at the same edge.
- `start` may be accepted in the cycle immediately after COMMIT; that is the earliest back-to-back frame.

## Test plan
- **All-ones frame:** `start`, then 143 ones and P=1 back-to-back.
  - `luts_config_in`=132'h…FFFF, mux=2'b11, `config_use_cc`=1, `regs_config_in`=8'hFF.
  - `done` pulse at edge 145; `cen` goes 1 then 0 at edge 145.
- **Field mapping:** a frame with only bit 0, bit 133 and bit 142 set, P=1.
  - `luts_config_in`[0]=1, `inter_lut_mux_config`=2'b10, `config_use_cc`=0, `regs_config_in`=8'h80.
- **Parity error:** the all-ones frame with P=0.
  - `err`=1 and `busy`=0 at edge 144; outputs keep their prior values; `cen` stays 1; no `done`.
  - A following good frame clears `err` at its `start`.
- **Stalls:** the all-ones frame with `bit_valid` low every third cycle.
  - Same final outputs; `done` is delayed by exactly the number of stall cycles.
- **`start` while busy:** pulse `start` at data bit 50.
  - Ignored; the frame completes at the normal edge with the correct data.
- **Reset mid-frame:** assert `rst` after 80 bits.
  - Outputs 0, `cen`=1, IDLE immediately; a subsequent full frame loads correctly.
